// File: rtl/digit_lock_controller.sv
// digit_lock_controller: digit entry, password compare/change, fail counting and timed lockout
module digit_lock_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_FAILS = 3,
  parameter int LOCK_TICKS = 30,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PASS = '0,
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int FW = $clog2(MAX_FAILS + 1),
  localparam int LW = $clog2(LOCK_TICKS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    btn_inc,
  input  logic                    btn_confirm,
  input  logic                    btn_enter,
  input  logic                    btn_change,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [CW-1:0]           cursor,
  output logic                    match,
  output logic                    change_mode,
  output logic                    locked,
  output logic [FW-1:0]           fail_count,
  output logic [LW-1:0]           lock_remaining
);
  typedef enum logic [1:0] {ENTRY, CHANGE, LOCKED} state_t;
  state_t state, state_n;
  logic [NUM_DIGITS-1:0][3:0] ent, ent_n;
  logic [4*NUM_DIGITS-1:0] stored, stored_n;
  logic [CW-1:0] cur_n;
  logic match_n;
  logic [FW-1:0] fail_n;
  logic [LW-1:0] rem_n;
  assign digits_out = ent;
  assign change_mode = state == CHANGE;
  assign locked = state == LOCKED;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ENTRY;
      stored <= DEFAULT_PASS;
      ent <= '0;
      cursor <= '0;
      match <= 1'b0;
      fail_count <= '0;
      lock_remaining <= '0;
    end else begin
      state <= state_n;
      stored <= stored_n;
      ent <= ent_n;
      cursor <= cur_n;
      match <= match_n;
      fail_count <= fail_n;
      lock_remaining <= rem_n;
    end
  end
  // one action per cycle: lockout countdown, else enter > change > confirm > inc
  always_comb begin
    state_n = state;
    stored_n = stored;
    ent_n = ent;
    cur_n = cursor;
    match_n = match;
    fail_n = fail_count;
    rem_n = lock_remaining;
    if (state == LOCKED) begin
      if (tick) begin
        rem_n = lock_remaining - 1'b1;
        if (lock_remaining == LW'(1)) begin
          state_n = ENTRY;
          fail_n = '0;
          match_n = 1'b0;
        end
      end
    end else if (btn_enter) begin
      ent_n = '0;
      cur_n = '0;
      if (state == CHANGE) begin
        stored_n = ent;
        state_n = ENTRY;
        fail_n = '0;
      end else if (ent == stored) begin
        match_n = 1'b1;
        fail_n = '0;
      end else begin
        match_n = 1'b0;
        fail_n = fail_count + 1'b1;
        if (fail_count == FW'(MAX_FAILS - 1)) begin
          state_n = LOCKED;
          rem_n = LW'(LOCK_TICKS);
        end
      end
    end else if (btn_change) begin
      if (state == CHANGE || match) begin
        state_n = (state == CHANGE) ? ENTRY : CHANGE;
        match_n = 1'b0;
        ent_n = '0;
        cur_n = '0;
      end
    end else if (btn_confirm) begin
      cur_n = (cursor == CW'(NUM_DIGITS - 1)) ? '0 : cursor + 1'b1;
      match_n = 1'b0;
    end else if (btn_inc) begin
      ent_n[cursor] = (ent[cursor] == 4'd9) ? 4'd0 : ent[cursor] + 4'd1;
      match_n = 1'b0;
    end
  end
endmodule

// File: doc/digit_lock_controller.md
Name: digit_lock_controller

Overview:
- Parametrised successor to the fixed 4-digit lock datapath: one synchronous block owning digit entry, password compare, change-password flow, fail counting and timed lockout.
- Generalised in digit count, fail threshold and lockout duration.
- Adds a timed auto-unlock and a cancellable change mode.
- Sits between the debounce/edge-detect stage (all button inputs are single-cycle pulses) and the 7-segment/LED drivers.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in entry and stored password (>=1).
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (>=1).
- LOCK_TICKS, 30, lockout duration in tick pulses (>=1).
- DEFAULT_PASS, 0, reset value of stored password, 4*NUM_DIGITS bits, digit i at [4i+3:4i]; each nibble must be 0-9.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  single-cycle timebase pulse for the lockout countdown.
- btn_inc  in  1  pulse: increment digit at cursor.
- btn_confirm  in  1  pulse: advance cursor.
- btn_enter  in  1  pulse: submit entry (compare, or commit new password in change mode).
- btn_change  in  1  pulse: enter or cancel change mode.
- digits_out  out  4*NUM_DIGITS  entry buffer, digit 0 at [3:0].
- cursor  out  CW=max(1,$clog2(NUM_DIGITS))  active digit index.
- match  out  1  last submission matched.
- change_mode  out  1  in CHANGE state.
- locked  out  1  in LOCKED state.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures.
- lock_remaining  out  $clog2(LOCK_TICKS+1)  ticks left in lockout.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=ENTRY; stored=DEFAULT_PASS; digits_out=0; cursor=0; match=0; change_mode=0; locked=0; fail_count=0; lock_remaining=0.
- All outputs are registered; each action is visible on the cycle after the pulse.
- Simultaneous pulses: at most one button is acted on per cycle. Priority: btn_enter > btn_change > btn_confirm > btn_inc; lower-priority pulses that cycle are dropped.
- btn_inc (ENTRY or CHANGE): digit[cursor] +1; 9 wraps to 0. Clears match.
- btn_confirm (ENTRY or CHANGE): cursor +1; NUM_DIGITS-1 wraps to 0. Clears match.
- ENTRY + btn_enter:
  - Compare the full buffer to stored.
  - Equal: match=1, fail_count=0.
  - Not equal: match=0, fail_count+1. If the new count equals MAX_FAILS: go to LOCKED, locked=1, lock_remaining=LOCK_TICKS, fail_count held at MAX_FAILS.
  - In all cases: buffer cleared to 0, cursor=0.
- ENTRY + btn_change:
  - If match=1: go to CHANGE, change_mode=1, match=0, buffer cleared, cursor=0.
  - If match=0: ignored.
- CHANGE + btn_enter: stored=buffer; go to ENTRY; change_mode=0; buffer cleared; cursor=0; fail_count=0.
- CHANGE + btn_change: cancel; stored unchanged; go to ENTRY; change_mode=0; buffer cleared; cursor=0.
- LOCKED:
  - btn_inc, btn_confirm, btn_enter and btn_change are all ignored; buffer and cursor hold.
  - On each tick: lock_remaining -1.
  - When tick arrives with lock_remaining==1: go to ENTRY next cycle, locked=0, lock_remaining=0, fail_count=0, match=0.
- tick has no effect outside LOCKED.
- Reset mid-operation (any state, including LOCKED or CHANGE) restores full reset values, including stored=DEFAULT_PASS.
- Comparison is a full-width equality over 4*NUM_DIGITS bits; no partial or early match.

Test Plan:
- Reset with DEFAULT_PASS=16'h1234; press inc 4x → confirm → inc 3x → confirm → inc 2x → confirm → inc 1x; then btn_enter → match=1, fail_count=0, digits_out=0, cursor=0.
- Cursor on digit 0 at value 9; btn_inc → digit 0 = 0. Cursor at 3 (NUM_DIGITS=4); btn_confirm → cursor=0.
- Enter 0000 three times (MAX_FAILS=3) → fail_count 1, 2, then locked=1, lock_remaining=30. btn_inc during lock → digits_out unchanged. 30 tick pulses → locked=0 one cycle after the 30th, fail_count=0.
- After a match, btn_change → change_mode=1; enter 5678 and btn_enter → change_mode=0. Entering 1234 → match=0, fail_count=1. Entering 5678 → match=1.
- In CHANGE with 9999 typed, btn_change → stored still 1234, change_mode=0. Same cycle btn_enter+btn_inc in ENTRY → only the compare occurs.
- Assert reset while LOCKED with lock_remaining=12 → locked=0, lock_remaining=0, fail_count=0 next cycle.
